stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM that sequences a centisecond stopwatch (MM:SS.cc) from a 100 Hz tick strobe and three button pulses. It owns the run/pause/lap/clear sequencing and the BCD time counters. It drives a 6-digit BCD value and a decimal-point pattern. A downstream fnd decoder plus six-digit scan multiplexer turns these into segments.

Parameters:
MIN_MAX, 59, terminal value of the minutes field before wrap (BCD-compared, 59 max)
BLINK_TICKS, 50, ticks per decimal-point blink half-period in PAUSE
DP_PATTERN, 6'b010100, decimal points lit (bit5 = leftmost digit) marking MM.SS.cc

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
i_tick  input  1  one-cycle 100 Hz strobe, NCO-derived
i_btn_start  input  1  one-cycle pulse, debounced; toggles run/pause
i_btn_lap  input  1  one-cycle pulse, debounced; lap freeze/release
i_btn_clr  input  1  one-cycle pulse, debounced; clear (PAUSE only)
o_digits  output  24  BCD {m10,m1,s10,s1,c10,c1}, 4 bits each, m10 at [23:20]
o_dp  output  6  decimal-point enables, active-high
o_run  output  1  1 in RUN or LAP
o_lap  output  1  1 in LAP (display frozen)
o_ovf  output  1  sticky; set on wrap past MIN_MAX:59.99

Behaviour:
- Reset: one clock with rst=1 has these effects. State goes to IDLE. All counters and the lap register go to 0. o_digits=24'h0, o_dp=DP_PATTERN, o_run=0, o_lap=0, o_ovf=0. Blink phase=1, blink count=0.
- rst takes priority over every input. Asserting rst mid-count aborts the count immediately.
- States: IDLE, RUN, LAP, PAUSE. Input priority is start > lap > clr when pulses coincide.
- IDLE: start goes to RUN. lap and clr are ignored.
- RUN: start goes to PAUSE. lap goes to LAP and copies the live count into the lap register in the same edge.
- LAP: lap goes to RUN. start goes to PAUSE, and the display returns to the live count.
- PAUSE: start goes to RUN. clr goes to IDLE, zeroes the counters and clears o_ovf. lap is ignored.
- Count enable is taken from the registered current state (RUN or LAP) AND i_tick.
  - A tick in the same cycle as start in IDLE is not counted.
  - A tick in the same cycle as start in RUN is counted.
- Counters are BCD and update on the edge where the tick is sampled.
  - c1 runs 0-9 and carries into c10 (0-9).
  - c10 carries into s1 (0-9), which carries into s10 (0-5).
  - s10 carries into m1/m10, up to MIN_MAX.
- Wrap: at MIN_MAX:59.99, the next tick produces 00:00.00 and sets o_ovf. o_ovf holds until clr or rst.
- o_digits is registered and reflects its source one cycle after the source changes.
  - In LAP the source is the lap register.
  - In all other states the source is the live count.
- o_dp:
  - In IDLE, RUN and LAP it equals DP_PATTERN.
  - In PAUSE it equals DP_PATTERN when blink phase=1, else 0.
  - The blink count increments on i_tick only in PAUSE. At BLINK_TICKS-1 it wraps to 0 and toggles the phase.
  - Entering PAUSE sets phase=1 and count=0.
- o_run and o_lap are decoded from the registered state.
- Buttons held high for several cycles are outside this block's contract. Inputs are pulses, and each asserted cycle counts as a press.

Decomposition:
- Shared package stopwatch_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, LAP=2'd2, PAUSE=2'd3);
  - the DP_PATTERN default;
  - BCD digit width 4;
  - the per-digit terminal constants 9 and 5.
- One natural sub-module, bcd_digit_cnt: a single decimal digit with a max parameter, ports clk, rst, i_clr, i_en (carry-in) and o_q[3:0], and a combinational o_carry equal to i_en AND (q==max). The top instantiates it 6 times; the minutes pair is handled with MIN_MAX compare logic.

Test Plan:
- Reset, then start, then 100 ticks: o_digits=24'h000100 (00:01.00), o_run=1, o_dp=6'b010100.
- Run to 00:12.34, pulse lap, then 50 more ticks: o_digits holds 24'h001234, o_lap=1. Pulse lap again: the next cycle shows 24'h001284.
- In RUN, pulse start: PAUSE, counters frozen. o_dp is 6'b010100 for 50 ticks, then 0 for 50 ticks, then repeats. Pulse clr: IDLE and o_digits=0.
- Preload to 59:59.99, one tick: o_digits=24'h000000 and o_ovf=1. o_ovf persists through start/pause and clears on clr.
- Coincident pulses:
  - start+lap in RUN goes to PAUSE, not LAP.
  - start+clr in PAUSE goes to RUN, not IDLE, with the count retained.
  - A tick coinciding with start from IDLE leaves the count at 0.
- rst asserted for one cycle during LAP at 03:21.07: the next cycle shows all outputs at reset values and state IDLE. Ticks without start do not count.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch controller.
// Holds the state encoding, BCD digit limits and the decimal-point layout.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_MAX_5 = 4'd5;

  // Decimal points after the minutes and seconds digits: MM.SS.cc
  localparam logic [5:0] DP_PATTERN_DEF = 6'b010100;

  function automatic logic [BCD_W-1:0] bcd_tens(input int value);
    return BCD_W'(value / 10);
  endfunction

  function automatic logic [BCD_W-1:0] bcd_ones(input int value);
    return BCD_W'(value % 10);
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One decimal counter digit: counts 0..MAX on i_en, wraps to 0, sync clear.
// o_carry is combinational so a chain of digits ripples within one cycle.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIGIT_MAX_9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [BCD_W-1:0] o_q,
  output logic             o_carry
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (i_clr) begin
      q_d = '0;
    end else if (i_en) begin
      q_d = (q_q == MAX) ? '0 : q_q + BCD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign o_q     = q_q;
  assign o_carry = i_en && (q_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/lap/clear FSM driving BCD MM:SS.cc counters,
// a lap capture register, a sticky overflow flag and the paused-state dp blink.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int         MIN_MAX     = 59,
  parameter int         BLINK_TICKS = 50,
  parameter logic [5:0] DP_PATTERN  = DP_PATTERN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_btn_start,
  input  logic        i_btn_lap,
  input  logic        i_btn_clr,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_run,
  output logic        o_lap,
  output logic        o_ovf
);

  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [BCD_W-1:0] MIN_TENS = bcd_tens(MIN_MAX);
  localparam logic [BCD_W-1:0] MIN_ONES = bcd_ones(MIN_MAX);

  state_e state_q, state_d;
  logic [23:0] lap_q, lap_d;
  logic [23:0] digits_q, digits_d;
  logic ovf_q, ovf_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_phase_q, blink_phase_d;

  logic [BCD_W-1:0] c1, c10, s1, s10, m1, m10;
  logic c1_carry, c10_carry, s1_carry, s10_carry, m1_carry, m10_carry;
  logic cnt_en, clr_req, cnt_clr, wrap, min_at_max;
  logic [23:0] live;

  assign live       = {m10, m1, s10, s1, c10, c1};
  assign cnt_en     = ((state_q == RUN) || (state_q == LAP)) && i_tick;
  assign clr_req    = (state_q == PAUSE) && i_btn_clr && !i_btn_start;
  assign min_at_max = (m10 == MIN_TENS) && (m1 == MIN_ONES);
  // Second term catches a 99-minute rollover if MIN_MAX is ever set that high.
  assign wrap       = (s10_carry && min_at_max) || m10_carry;
  assign cnt_clr    = clr_req || wrap;

  bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_c1 (
    .clk(clk), .rst(rst), .i_clr(cnt_clr), .i_en(cnt_en),
    .o_q(c1), .o_carry(c1_carry)
  );

  bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_c10 (
    .clk(clk), .rst(rst), .i_clr(cnt_clr), .i_en(c1_carry),
    .o_q(c10), .o_carry(c10_carry)
  );

  bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_s1 (
    .clk(clk), .rst(rst), .i_clr(cnt_clr), .i_en(c10_carry),
    .o_q(s1), .o_carry(s1_carry)
  );

  bcd_digit_cnt #(.MAX(DIGIT_MAX_5)) u_s10 (
    .clk(clk), .rst(rst), .i_clr(cnt_clr), .i_en(s1_carry),
    .o_q(s10), .o_carry(s10_carry)
  );

  // Minutes stop advancing at MIN_MAX; the wrap clear takes over there.
  bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_m1 (
    .clk(clk), .rst(rst), .i_clr(cnt_clr), .i_en(s10_carry && !min_at_max),
    .o_q(m1), .o_carry(m1_carry)
  );

  bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_m10 (
    .clk(clk), .rst(rst), .i_clr(cnt_clr), .i_en(m1_carry),
    .o_q(m10), .o_carry(m10_carry)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_btn_start) state_d = RUN;
      end
      RUN: begin
        if (i_btn_start)    state_d = PAUSE;
        else if (i_btn_lap) state_d = LAP;
      end
      LAP: begin
        if (i_btn_start)    state_d = PAUSE;
        else if (i_btn_lap) state_d = RUN;
      end
      PAUSE: begin
        if (i_btn_start)    state_d = RUN;
        else if (i_btn_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lap_d         = lap_q;
    digits_d      = (state_q == LAP) ? lap_q : live;
    ovf_d         = ovf_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if ((state_q == RUN) && i_btn_lap && !i_btn_start) begin
      lap_d = live;
    end

    if (clr_req) begin
      ovf_d = 1'b0;
    end else if (wrap) begin
      ovf_d = 1'b1;
    end

    // Every entry into PAUSE restarts the blink with the points lit.
    if ((state_d == PAUSE) && (state_q != PAUSE)) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if ((state_q == PAUSE) && i_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lap_q         <= '0;
      digits_q      <= '0;
      ovf_q         <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      lap_q         <= lap_d;
      digits_q      <= digits_d;
      ovf_q         <= ovf_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign o_digits = digits_q;
  assign o_dp     = ((state_q == PAUSE) && !blink_phase_q) ? 6'b000000 : DP_PATTERN;
  assign o_run    = (state_q == RUN) || (state_q == LAP);
  assign o_lap    = (state_q == LAP);
  assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed and randomized bench for stopwatch_ctrl against a time-in-centiseconds model.
// MIN_MAX is lowered to 3 so the minutes wrap is reachable in a short run.
module tb_stopwatch_ctrl;

  localparam int         MIN_MAX_TB = 3;
  localparam int         BLINK      = 50;
  localparam logic [5:0] DP         = 6'b010100;
  localparam int         WRAP_CS    = (MIN_MAX_TB + 1) * 6000;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_LAP   = 2;
  localparam int M_PAUSE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_tick = 1'b0;
  logic        i_btn_start = 1'b0;
  logic        i_btn_lap = 1'b0;
  logic        i_btn_clr = 1'b0;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic        o_run;
  logic        o_lap;
  logic        o_ovf;

  int vectors = 0;
  int miscompares = 0;

  int   m_state = M_IDLE;
  int   m_cs = 0;
  int   m_lap_cs = 0;
  int   m_disp = 0;
  int   m_pause_ticks = 0;
  logic m_ovf = 1'b0;

  stopwatch_ctrl #(
    .MIN_MAX(MIN_MAX_TB),
    .BLINK_TICKS(BLINK),
    .DP_PATTERN(DP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_tick(i_tick),
    .i_btn_start(i_btn_start),
    .i_btn_lap(i_btn_lap),
    .i_btn_clr(i_btn_clr),
    .o_digits(o_digits),
    .o_dp(o_dp),
    .o_run(o_run),
    .o_lap(o_lap),
    .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] toBcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic checkVal(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic s, input logic l, input logic c, input logic t, input logic r);
    int nxt_disp;
    int nxt_state;
    if (r) begin
      m_state = M_IDLE;
      m_cs = 0;
      m_lap_cs = 0;
      m_disp = 0;
      m_pause_ticks = 0;
      m_ovf = 1'b0;
    end else begin
      nxt_disp = (m_state == M_LAP) ? m_lap_cs : m_cs;
      if (m_state == M_PAUSE && t) m_pause_ticks++;
      if (m_state == M_RUN && l && !s) m_lap_cs = m_cs;
      if (m_state == M_PAUSE && c && !s) begin
        m_cs = 0;
        m_ovf = 1'b0;
      end
      if ((m_state == M_RUN || m_state == M_LAP) && t) begin
        m_cs++;
        if (m_cs == WRAP_CS) begin
          m_cs = 0;
          m_ovf = 1'b1;
        end
      end
      nxt_state = m_state;
      case (m_state)
        M_IDLE:  if (s) nxt_state = M_RUN;
        M_RUN:   if (s) nxt_state = M_PAUSE; else if (l) nxt_state = M_LAP;
        M_LAP:   if (s) nxt_state = M_PAUSE; else if (l) nxt_state = M_RUN;
        M_PAUSE: if (s) nxt_state = M_RUN; else if (c) nxt_state = M_IDLE;
        default: nxt_state = M_IDLE;
      endcase
      if (nxt_state == M_PAUSE && m_state != M_PAUSE) m_pause_ticks = 0;
      m_state = nxt_state;
      m_disp = nxt_disp;
    end
  endtask

  task automatic checkOutput();
    logic [5:0] exp_dp;
    exp_dp = (m_state == M_PAUSE && ((m_pause_ticks / BLINK) % 2) != 0) ? 6'b000000 : DP;
    checkVal("digits", o_digits, toBcd(m_disp));
    checkVal("dp", {18'b0, o_dp}, {18'b0, exp_dp});
    checkVal("run", {23'b0, o_run}, {23'b0, (m_state == M_RUN || m_state == M_LAP)});
    checkVal("lap", {23'b0, o_lap}, {23'b0, (m_state == M_LAP)});
    checkVal("ovf", {23'b0, o_ovf}, {23'b0, m_ovf});
  endtask

  task automatic applyStimulus(input logic s, input logic l, input logic c, input logic t, input logic r);
    i_btn_start = s;
    i_btn_lap   = l;
    i_btn_clr   = c;
    i_tick      = t;
    rst         = r;
    @(posedge clk);
    modelStep(s, l, c, t, r);
    #1;
    i_btn_start = 1'b0;
    i_btn_lap   = 1'b0;
    i_btn_clr   = 1'b0;
    i_tick      = 1'b0;
    rst         = 1'b0;
    checkOutput();
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #2;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("reset_digits", o_digits, 24'h000000);
    checkVal("reset_dp", {18'b0, o_dp}, {18'b0, DP});
    checkVal("reset_run", {23'b0, o_run}, 24'h0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("start_tick_not_counted", o_digits, 24'h000000);
    runTicks(100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("one_second", o_digits, 24'h000100);
    checkVal("run_flag", {23'b0, o_run}, 24'h1);

    runTicks(1234 - m_cs);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(50);
    checkVal("lap_frozen", o_digits, 24'h001234);
    checkVal("lap_flag", {23'b0, o_lap}, 24'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("lap_release", o_digits, 24'h001284);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(49);
    checkVal("blink_on", {18'b0, o_dp}, {18'b0, DP});
    runTicks(1);
    checkVal("blink_off", {18'b0, o_dp}, 24'h0);
    runTicks(50);
    checkVal("blink_on_again", {18'b0, o_dp}, {18'b0, DP});
    runTicks(20);
    checkVal("pause_frozen", o_digits, 24'h001284);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("clear_digits", o_digits, 24'h000000);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(37);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkVal("start_over_lap_run", {23'b0, o_run}, 24'h0);
    checkVal("start_over_lap_lap", {23'b0, o_lap}, 24'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("start_over_clr", o_digits, 24'h000038);
    checkVal("start_over_clr_run", {23'b0, o_run}, 24'h1);

    runTicks(3 * 6000 + 2107 - m_cs);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("lap_at_032107", o_digits, 24'h032107);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("rst_in_lap_digits", o_digits, 24'h000000);
    checkVal("rst_in_lap_lap", {23'b0, o_lap}, 24'h0);
    runTicks(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("idle_ticks_ignored", o_digits, 24'h000000);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(WRAP_CS - 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("at_max", o_digits, 24'h035999);
    runTicks(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("wrap_digits", o_digits, 24'h000000);
    checkVal("wrap_ovf", {23'b0, o_ovf}, 24'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("ovf_sticky", {23'b0, o_ovf}, 24'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("ovf_cleared", {23'b0, o_ovf}, 24'h0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 0,
                    $urandom_range(0, 255) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
